cpu_top: RTL and testbench
==========================

Name: cpu_top

Overview:
- Multi-cycle SIMD processor core with 18-bit instructions and a 3-entry 16-bit register file (R0..R2).
- Each register is viewed as one 16-bit lane (H), two 8-bit lanes (O) or four 4-bit lanes (Q), selected by the opcode.
- Fetches from an external instruction memory and loads/stores words in an external data memory; both memories update on the falling clock edge.
- Supports a hardware loop counter and a halt instruction that raises done.

Parameters:
- IW, 18, instruction width
- DW, 16, data/register width
- AW, 10, instruction and data address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- instruction_in  in  18  instruction word at instruction_addr
- data_in  in  16  read data from data memory
- data_out  out  16  store data (registered)
- instruction_addr  out  10  PC (registered)
- data_addr  out  10  data memory address (registered)
- data_R  out  1  memory access enable
- data_W  out  1  write qualifier; memory writes only when data_R=1 and data_W=1
- done  out  1  high once halt has executed

Behaviour:
- Reset (rst=0, async): PC, R0..R2, LC, IR = 0; all outputs 0; state FETCH.
- States:
  - FETCH: instruction_addr=PC. On exit, IR <= instruction_in.
  - EXEC: decode IR. ALU/set/loop ops write back, update PC, go to FETCH. Load/store: set data_addr=imm, data_R=1, data_W=(store), data_out=Rd; go to MEM. Halt: go to HALT.
  - MEM: memory acts on the falling edge. On exit: a load writes data_in to Rd; data_R=data_W=0; PC+1; go to FETCH.
  - HALT: done=1; PC and state frozen until reset.
- Latency: non-memory instructions take 2 cycles; load/store take 3 cycles.
- Formats:
  - Register-register: [17:12] op, [3:2] Rd, [1:0] Rs. Rd = Rd op Rs.
  - Immediate: [11:10] Rd, [9:0] imm.
  - Single-register (shift/not): [1:0] Rd.
  - MAC: [5:4] Rd, [3:2] Ra, [1:0] Rb. Rd = Rd + Ra*Rb.
- Lane immediates: 16-bit ops zero-extend imm; 8-bit ops replicate imm[7:0] into both bytes; 4-bit ops replicate imm[3:0] into all nibbles.
- Arithmetic:
  - Per lane, modulo 2^w; no carry or borrow across lanes.
  - mul keeps the low w bits of the product.
  - Shifts are logical by 1 per lane; zero fill.
- Opcodes (16/8/4-bit variants):
  - add rr 0/1/2; add imm 3/4/5
  - sub rr 6/7/8; sub imm 9/10/11
  - mul rr 12/13/14; mul imm 15/16/17
  - mac 18/19/20; shl 21/22/23; shr 24/25/26
  - and 27/28/29; or 30/31/32; not 33/34/35
  - loopjump 36; setloop 37
  - load 38/39/40; store 41/42/43; set 44/45/46
  - halt 63
- Load/store: all widths transfer the full 16-bit word.
- set: Rd = lane-replicated imm.
- setloop: LC (10-bit) = imm; PC+1.
- loopjump: if LC≠0, LC -= 1 and PC = imm; else PC+1. With setloop n, the body executes n+1 times.
- Register index 3: reads as 0, writes are ignored.
- Undefined opcodes: NOP (PC+1).
- PC wraps from 1023 to 0.
- Reset mid-access deasserts data_R and data_W immediately.

Decomposition:
- Package cpu_pkg: opcode localparams, state enum, lane-width enum, field-slice constants.
- Sub-module simd_alu: combinational lane-wise add/sub/mul/mac/shift/logic/not/replicate, inputs width select and operands.
- cpu_top holds the FSM, PC, LC, register file and memory interface.

Test Plan:
- Load mem0=5 into R0 and mem1=15 into R1; add16 R0,R1; store R0→mem0 -> mem0=0x0014; data_R=data_W=1 for exactly one cycle.
- set8 R1 imm=0x05A -> R1=0x5A5A. set4 R2 same imm -> 0xAAAA. shl4 R2 -> 0x4444. add4 imm 14 -> 0x2222. sub4 imm 14 -> 0x4444. not4 -> 0xBBBB.
- set16 R0=15, R1=4, R2=2; mac16 R0,R1,R2 -> R0=0x0017. mac8 on 0x0F0F/0x0404/0x0202 -> 0x1717. shr8 0x5AD4 -> 0x2D6A.
- mul16 imm 13 on R1=4 -> 0x0034. add8 imm 14 on 0x0068 -> 0x0E76; verify no inter-lane carry.
- setloop 2 + loopjump to body start -> body executes 3 times; LC=0; falls through to halt -> done=1; PC frozen.
- Assert rst low during a store's MEM cycle -> outputs 0 immediately; restart fetches address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_top SIMD core.
// Holds the instruction field positions, opcode values, the FSM state enum,
// the lane-width enum and the ALU operation enum used by cpu_top and simd_alu.
package cpu_pkg;

    // Bit positions of the instruction fields (18-bit instruction word)
    localparam int OP_LSB   = 12;   // opcode [17:12]
    localparam int IMRD_LSB = 10;   // immediate-format Rd [11:10]
    localparam int RRD_LSB  = 2;    // register-format Rd [3:2] / MAC Ra
    localparam int MACD_LSB = 4;    // MAC Rd [5:4]

    // Opcodes 0..35 form twelve groups of three (16/8/4-bit lane variants).
    // Group index = opcode / 3, lane select = opcode % 3.
    localparam logic [5:0] OP_LANE_LAST = 6'd35;
    localparam logic [5:0] OP_LOOPJUMP  = 6'd36;
    localparam logic [5:0] OP_SETLOOP   = 6'd37;
    localparam logic [5:0] OP_LOAD      = 6'd38;
    localparam logic [5:0] OP_STORE     = 6'd41;
    localparam logic [5:0] OP_SET       = 6'd44;
    localparam logic [5:0] OP_HALT      = 6'd63;

    localparam logic [3:0] GRP_ADD_RR = 4'd0;
    localparam logic [3:0] GRP_ADD_IM = 4'd1;
    localparam logic [3:0] GRP_SUB_RR = 4'd2;
    localparam logic [3:0] GRP_SUB_IM = 4'd3;
    localparam logic [3:0] GRP_MUL_RR = 4'd4;
    localparam logic [3:0] GRP_MUL_IM = 4'd5;
    localparam logic [3:0] GRP_MAC    = 4'd6;
    localparam logic [3:0] GRP_SHL    = 4'd7;
    localparam logic [3:0] GRP_SHR    = 4'd8;
    localparam logic [3:0] GRP_AND    = 4'd9;
    localparam logic [3:0] GRP_OR     = 4'd10;
    localparam logic [3:0] GRP_NOT    = 4'd11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    // Lane view of a 16-bit register: one 16-bit, two 8-bit or four 4-bit lanes
    typedef enum logic [1:0] {
        LANE_H = 2'd0,
        LANE_O = 2'd1,
        LANE_Q = 2'd2
    } lane_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_MAC, ALU_SHL,
        ALU_SHR, ALU_AND, ALU_OR,  ALU_NOT, ALU_PASS
    } alu_op_e;

endpackage

// File: rtl/cpu_simd_alu.sv
// simd_alu: combinational lane-wise ALU.
// Ports:
//   i_lane    lane width select (16/8/4-bit lanes)
//   i_op      operation
//   i_use_imm when set, operand B is the lane-replicated immediate i_imm
//   i_a, i_b  operands (i_a = Rd or Ra, i_b = Rs or Rb)
//   i_c       accumulator input for MAC (Rd)
//   o_y       result
module simd_alu
    import cpu_pkg::*;
(
    input  lane_e       i_lane,
    input  alu_op_e     i_op,
    input  logic        i_use_imm,
    input  logic [9:0]  i_imm,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    output logic [15:0] o_y
);

    logic [15:0] w_b;
    logic [15:0] w_res;

    // Operates on one zero-extended lane; the caller keeps only the low
    // lane-width bits, which gives modulo-2^w results without any cross-lane
    // carry, borrow or shift bleed.
    function automatic logic [15:0] f_lane(input alu_op_e op,
                                           input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] c);
        logic [15:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_MUL:  y = a * b;
            ALU_MAC:  y = c + a * b;
            ALU_SHL:  y = a << 1;
            ALU_SHR:  y = a >> 1;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_NOT:  y = ~a;
            ALU_PASS: y = b;
            default:  y = a;
        endcase
        return y;
    endfunction

    always_comb begin
        w_b   = i_b;
        w_res = '0;
        o_y   = '0;
        if (i_use_imm) begin
            case (i_lane)
                LANE_O:  w_b = {2{i_imm[7:0]}};
                LANE_Q:  w_b = {4{i_imm[3:0]}};
                default: w_b = {6'b0, i_imm};
            endcase
        end
        case (i_lane)
            LANE_O: begin
                for (int k = 0; k < 2; k++) begin
                    w_res = f_lane(i_op, {8'b0, i_a[k*8 +: 8]}, {8'b0, w_b[k*8 +: 8]},
                                   {8'b0, i_c[k*8 +: 8]});
                    o_y[k*8 +: 8] = w_res[7:0];
                end
            end
            LANE_Q: begin
                for (int k = 0; k < 4; k++) begin
                    w_res = f_lane(i_op, {12'b0, i_a[k*4 +: 4]}, {12'b0, w_b[k*4 +: 4]},
                                   {12'b0, i_c[k*4 +: 4]});
                    o_y[k*4 +: 4] = w_res[3:0];
                end
            end
            default: o_y = f_lane(i_op, i_a, w_b, i_c);
        endcase
    end

endmodule

// File: rtl/cpu_top.sv
// cpu_top: multi-cycle SIMD core, 3 x 16-bit registers, 10-bit loop counter.
// FETCH -> EXEC -> (MEM ->) FETCH; halt parks the core in HALT until reset.
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-low reset
//   instruction_in   instruction word at instruction_addr
//   data_in          data memory read data
//   data_out         store data (registered)
//   instruction_addr program counter (registered)
//   data_addr        data memory address (registered)
//   data_R           memory access enable
//   data_W           write qualifier (write when data_R && data_W)
//   done             high while halted
// The field decode assumes the default widths (IW=18, DW=16, AW=10).
module cpu_top
    import cpu_pkg::*;
#(
    parameter int IW = 18,
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instruction_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic [AW-1:0] instruction_addr,
    output logic [AW-1:0] data_addr,
    output logic          data_R,
    output logic          data_W,
    output logic          done
);

    state_e      r_state, w_state_nxt;
    logic [9:0]  r_pc, r_lc;
    logic [17:0] r_ir;
    logic [15:0] r_rf [0:2];
    logic [15:0] r_data_out;
    logic [9:0]  r_data_addr;
    logic        r_data_R, r_data_W;

    logic [5:0]  w_op;
    logic [3:0]  w_grp;
    logic [1:0]  w_lsel, w_set_sel;
    logic [1:0]  w_im_d, w_rr_d, w_rr_s, w_mac_d;
    logic [9:0]  w_imm;
    logic [15:0] w_rv [0:3];
    alu_op_e     w_alu_op;
    lane_e       w_lane;
    logic        w_use_imm, w_wr_en, w_is_mem, w_is_store, w_is_halt;
    logic [1:0]  w_wr_idx;
    logic [15:0] w_a, w_b, w_c, w_alu_y;
    logic [9:0]  w_pc_nxt, w_lc_nxt;

    // Register index 3 reads as zero
    assign w_rv[0] = r_rf[0];
    assign w_rv[1] = r_rf[1];
    assign w_rv[2] = r_rf[2];
    assign w_rv[3] = '0;

    assign w_op      = r_ir[17:OP_LSB];
    assign w_grp     = 4'(w_op / 6'd3);
    assign w_lsel    = 2'(w_op % 6'd3);
    assign w_set_sel = 2'(w_op - OP_SET);
    assign w_im_d    = r_ir[IMRD_LSB +: 2];
    assign w_imm     = r_ir[9:0];
    assign w_rr_d    = r_ir[RRD_LSB +: 2];
    assign w_rr_s    = r_ir[1:0];
    assign w_mac_d   = r_ir[MACD_LSB +: 2];

    always_comb begin
        w_alu_op   = ALU_PASS;
        w_lane     = LANE_H;
        w_use_imm  = 1'b0;
        w_a        = '0;
        w_b        = '0;
        w_c        = '0;
        w_wr_en    = 1'b0;
        w_wr_idx   = w_im_d;
        w_is_mem   = 1'b0;
        w_is_store = 1'b0;
        w_is_halt  = 1'b0;
        w_pc_nxt   = r_pc + 10'd1;
        w_lc_nxt   = r_lc;
        if (w_op <= OP_LANE_LAST) begin
            w_lane   = lane_e'(w_lsel);
            w_wr_en  = 1'b1;
            w_wr_idx = w_rr_d;
            w_a      = w_rv[w_rr_d];
            w_b      = w_rv[w_rr_s];
            case (w_grp)
                GRP_ADD_RR: w_alu_op = ALU_ADD;
                GRP_ADD_IM: begin w_alu_op = ALU_ADD; w_use_imm = 1'b1; end
                GRP_SUB_RR: w_alu_op = ALU_SUB;
                GRP_SUB_IM: begin w_alu_op = ALU_SUB; w_use_imm = 1'b1; end
                GRP_MUL_RR: w_alu_op = ALU_MUL;
                GRP_MUL_IM: begin w_alu_op = ALU_MUL; w_use_imm = 1'b1; end
                GRP_MAC:    w_alu_op = ALU_MAC;
                GRP_SHL:    w_alu_op = ALU_SHL;
                GRP_SHR:    w_alu_op = ALU_SHR;
                GRP_AND:    w_alu_op = ALU_AND;
                GRP_OR:     w_alu_op = ALU_OR;
                default:    w_alu_op = ALU_NOT;
            endcase
            // Immediate forms take Rd from [11:10]; shift/not and MAC move Rd too
            if (w_use_imm) begin
                w_wr_idx = w_im_d;
                w_a      = w_rv[w_im_d];
            end else if (w_grp == GRP_MAC) begin
                w_wr_idx = w_mac_d;
                w_c      = w_rv[w_mac_d];
                w_a      = w_rv[w_rr_d];
            end else if (w_grp == GRP_SHL || w_grp == GRP_SHR || w_grp == GRP_NOT) begin
                w_wr_idx = w_rr_s;
                w_a      = w_rv[w_rr_s];
            end
        end else begin
            case (w_op)
                OP_LOOPJUMP: begin
                    if (r_lc != '0) begin
                        w_lc_nxt = r_lc - 10'd1;
                        w_pc_nxt = w_imm;
                    end
                end
                OP_SETLOOP: w_lc_nxt = w_imm;
                6'd38, 6'd39, 6'd40: w_is_mem = 1'b1;
                6'd41, 6'd42, 6'd43: begin w_is_mem = 1'b1; w_is_store = 1'b1; end
                6'd44, 6'd45, 6'd46: begin
                    w_lane    = lane_e'(w_set_sel);
                    w_use_imm = 1'b1;
                    w_wr_en   = 1'b1;
                end
                OP_HALT: w_is_halt = 1'b1;
                default: ;
            endcase
        end
    end

    simd_alu u_alu (
        .i_lane    (w_lane),
        .i_op      (w_alu_op),
        .i_use_imm (w_use_imm),
        .i_imm     (w_imm),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_c       (w_c),
        .o_y       (w_alu_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)     w_state_nxt = S_HALT;
                else if (w_is_mem) w_state_nxt = S_MEM;
                else               w_state_nxt = S_FETCH;
            end
            S_MEM:   w_state_nxt = S_FETCH;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= '0;
            r_lc        <= '0;
            r_ir        <= '0;
            r_data_out  <= '0;
            r_data_addr <= '0;
            r_data_R    <= 1'b0;
            r_data_W    <= 1'b0;
            for (int i = 0; i < 3; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_ir <= instruction_in;
                S_EXEC: begin
                    if (w_is_mem) begin
                        r_data_addr <= w_imm;
                        r_data_R    <= 1'b1;
                        r_data_W    <= w_is_store;
                        r_data_out  <= w_rv[w_im_d];
                    end else if (!w_is_halt) begin
                        for (int i = 0; i < 3; i++)
                            if (w_wr_en && w_wr_idx == 2'(i)) r_rf[i] <= w_alu_y;
                        r_pc <= w_pc_nxt;
                        r_lc <= w_lc_nxt;
                    end
                end
                S_MEM: begin
                    // Only loads and stores reach MEM, so !data_W means load
                    for (int i = 0; i < 3; i++)
                        if (!r_data_W && w_im_d == 2'(i)) r_rf[i] <= data_in;
                    r_data_R <= 1'b0;
                    r_data_W <= 1'b0;
                    r_pc     <= r_pc + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign instruction_addr = r_pc;
    assign data_addr        = r_data_addr;
    assign data_out         = r_data_out;
    assign data_R           = r_data_R;
    assign data_W           = r_data_W;
    assign done             = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_top.sv
module tb_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] instruction_in;
    logic [15:0] data_in, data_out;
    logic [9:0]  instruction_addr, data_addr;
    logic        data_R, data_W, done;

    logic [17:0] imem [0:1023];
    logic [15:0] dmem [0:1023];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;
    logic        prev_w = 1'b0;
    int          p = 0;
    int          body_pc = 0;
    int          halt_pc = 0;

    always #5 clk = ~clk;

    assign instruction_in = imem[instruction_addr];
    assign data_in        = dmem[data_addr];

    cpu_top dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_in   (instruction_in),
        .data_in          (data_in),
        .data_out         (data_out),
        .instruction_addr (instruction_addr),
        .data_addr        (data_addr),
        .data_R           (data_R),
        .data_W           (data_W),
        .done             (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Data memory writes on the falling edge; every write is checked in order
    always @(negedge clk) begin
        if (rst && data_R && data_W) begin
            dmem[data_addr] = data_out;
            chk("store_single_cycle", 32'(prev_w), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL store_unexpected: got addr=%h data=%h want none", data_addr, data_out);
            end else begin
                chk("store", {6'b0, data_addr, data_out}, exp_q.pop_front());
            end
        end
        prev_w = rst && data_W;
    end

    function automatic logic [17:0] im(input int op, input int rd, input int imm);
        return {op[5:0], rd[1:0], imm[9:0]};
    endfunction
    function automatic logic [17:0] rr(input int op, input int rd, input int rs);
        return {op[5:0], 8'b0, rd[1:0], rs[1:0]};
    endfunction
    function automatic logic [17:0] mac(input int op, input int rd, input int ra, input int rb);
        return {op[5:0], 6'b0, rd[1:0], ra[1:0], rb[1:0]};
    endfunction
    function automatic logic [17:0] one(input int op, input int rd);
        return {op[5:0], 10'b0, rd[1:0]};
    endfunction

    task automatic emit(input logic [17:0] w);
        imem[p] = w;
        p++;
    endtask

    task automatic push_e(input int a, input int d);
        exp_q.push_back({6'b0, a[9:0], d[15:0]});
    endtask

    task automatic init_dmem();
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        dmem[0]  = 16'd5;
        dmem[1]  = 16'd15;
        dmem[10] = 16'h5AD4;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) imem[i] = '0;
        p = 0;
        emit(im(38, 0, 0));  emit(im(38, 1, 1));  emit(rr(0, 0, 1));  emit(im(41, 0, 0));
        emit(im(45, 1, 'h5A)); emit(im(41, 1, 2));
        emit(im(46, 2, 'h5A)); emit(im(41, 2, 3));
        emit(one(23, 2));    emit(im(41, 2, 4));
        emit(im(5, 2, 14));  emit(im(41, 2, 5));
        emit(im(11, 2, 14)); emit(im(41, 2, 6));
        emit(one(35, 2));    emit(im(41, 2, 7));
        emit(im(44, 0, 15)); emit(im(44, 1, 4)); emit(im(44, 2, 2));
        emit(mac(18, 0, 1, 2)); emit(im(41, 0, 8));
        emit(im(45, 0, 'h0F)); emit(im(45, 1, 4)); emit(im(45, 2, 2));
        emit(mac(19, 0, 1, 2)); emit(im(41, 0, 9));
        emit(im(38, 1, 10)); emit(one(25, 1));   emit(im(41, 1, 11));
        emit(im(44, 1, 4));  emit(im(15, 1, 13)); emit(im(41, 1, 12));
        emit(im(44, 2, 'h68)); emit(im(4, 2, 14)); emit(im(41, 2, 13));
        emit(im(44, 0, 'hFF)); emit(im(4, 0, 1)); emit(im(41, 0, 14));
        emit(im(44, 1, 'h3C)); emit(rr(31, 0, 1)); emit(im(41, 0, 15));
        emit(rr(0, 0, 3));   emit({6'd50, 12'hFFF}); emit(im(41, 0, 16));
        emit(im(44, 2, 0));  emit(im(37, 0, 2));
        body_pc = p;
        emit(im(3, 2, 1));   emit(im(41, 2, 17)); emit(im(36, 0, body_pc));
        halt_pc = p;
        emit({6'd63, 12'd0});
    endtask

    task automatic push_all();
        push_e(0, 'h0014);  push_e(2, 'h5A5A);  push_e(3, 'hAAAA);  push_e(4, 'h4444);
        push_e(5, 'h2222);  push_e(6, 'h4444);  push_e(7, 'hBBBB);  push_e(8, 'h0017);
        push_e(9, 'h1717);  push_e(11, 'h2D6A); push_e(12, 'h0034); push_e(13, 'h0E76);
        push_e(14, 'h0100); push_e(15, 'h013C); push_e(16, 'h013C);
        push_e(17, 1);      push_e(17, 2);      push_e(17, 3);
    endtask

    task automatic run_to_halt();
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done", 32'(done), 32'd1);
        chk("halt_pc", 32'(instruction_addr), 32'(halt_pc));
        repeat (4) @(posedge clk);
        #1;
        chk("pc_frozen", 32'(instruction_addr), 32'(halt_pc));
        chk("done_held", 32'(done), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mem0_final", 32'(dmem[0]), 32'h14);
        chk("loop_count", 32'(dmem[17]), 32'd3);
    endtask

    initial begin
        logic hit;
        init_dmem();
        load_prog();
        #1;
        chk("rst_pc",    32'(instruction_addr), 32'd0);
        chk("rst_dR",    32'(data_R), 32'd0);
        chk("rst_dW",    32'(data_W), 32'd0);
        chk("rst_dout",  32'(data_out), 32'd0);
        chk("rst_daddr", 32'(data_addr), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_held", 32'(instruction_addr), 32'd0);

        push_all();
        @(negedge clk) rst = 1'b1;
        run_to_halt();

        // Restart, then pull reset in the middle of the first store
        @(negedge clk) rst = 1'b0;
        init_dmem();
        @(negedge clk) rst = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            if (data_W) hit = 1'b1;
        end
        chk("store_reached", 32'(hit), 32'd1);
        chk("abort_store_data", 32'(data_out), 32'h14);
        rst = 1'b0;
        #1;
        chk("abort_dR",    32'(data_R), 32'd0);
        chk("abort_dW",    32'(data_W), 32'd0);
        chk("abort_dout",  32'(data_out), 32'd0);
        chk("abort_daddr", 32'(data_addr), 32'd0);
        chk("abort_pc",    32'(instruction_addr), 32'd0);
        chk("abort_done",  32'(done), 32'd0);

        init_dmem();
        push_all();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("restart_pc", 32'(instruction_addr), 32'd0);
        run_to_halt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
